// File: rtl/freq_div_multi_if.sv
// Configuration write port of freq_div_multi: one-cycle write strobe plus registered reject pulse.
// Defining FREQ_DIV_MULTI_PHASE_EN adds cfg_phase to the port.
interface freq_div_multi_if #(
  parameter int WIDTH   = 8,
  parameter int CH_BITS = 1
);
  logic               cfg_wr;
  logic [CH_BITS-1:0] cfg_ch;
  logic [WIDTH-1:0]   cfg_div;
  logic [WIDTH-1:0]   cfg_high;
  logic               cfg_err;
`ifdef FREQ_DIV_MULTI_PHASE_EN
  logic [WIDTH-1:0]   cfg_phase;

  modport master (output cfg_wr, cfg_ch, cfg_div, cfg_high, cfg_phase, input cfg_err);
  modport slave  (input cfg_wr, cfg_ch, cfg_div, cfg_high, cfg_phase, output cfg_err);
`else
  modport master (output cfg_wr, cfg_ch, cfg_div, cfg_high, input cfg_err);
  modport slave  (input cfg_wr, cfg_ch, cfg_div, cfg_high, output cfg_err);
`endif
endinterface

// File: rtl/freq_div_multi.sv
// Multi-channel programmable clock divider with double-buffered period/high-time per channel.
// Optional FREQ_DIV_MULTI_PHASE_EN: start-of-run phase offset captured with each config write.
module freq_div_multi #(
  parameter int NUM_CH   = 2,
  parameter int WIDTH    = 8,
  parameter int CH_BITS  = 1,
  parameter int RST_DIV  = 2,
  parameter int RST_HIGH = 1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              clear,
  input  logic [NUM_CH-1:0] en,
  freq_div_multi_if.slave   cfg,
  output logic [NUM_CH-1:0] div,
  output logic [NUM_CH-1:0] tc,
  output logic [NUM_CH-1:0] pend
);

  typedef enum logic {ST_START, ST_RUN} state_e;

  typedef struct packed {
    state_e           state;
    logic [WIDTH-1:0] count;
    logic [WIDTH-1:0] div_act;
    logic [WIDTH-1:0] high_act;
    logic [WIDTH-1:0] div_sh;
    logic [WIDTH-1:0] high_sh;
`ifdef FREQ_DIV_MULTI_PHASE_EN
    logic [WIDTH-1:0] phase_act;
    logic [WIDTH-1:0] phase_sh;
`endif
  } ch_t;

  ch_t               ch_q [NUM_CH];
  ch_t               ch_d [NUM_CH];
  ch_t               ch_ap;
  logic [WIDTH-1:0]  start_pos;
  logic [NUM_CH-1:0] div_q, div_d;
  logic [NUM_CH-1:0] tc_q, tc_d;
  logic [NUM_CH-1:0] pend_q, pend_d;
  logic              err_q, err_d;
  logic              wr_ok;

  assign wr_ok = cfg.cfg_wr && (cfg.cfg_div >= WIDTH'(2)) && (int'(cfg.cfg_ch) < NUM_CH);

  // NOTE: defaults are assigned first so every path drives every variable; no latches inferred.
  always_comb begin
    ch_d      = ch_q;
    div_d     = div_q;
    tc_d      = '0;
    pend_d    = pend_q;
    err_d     = !clear && cfg.cfg_wr && !wr_ok;
    ch_ap     = ch_q[0];
    start_pos = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      // ch_ap is the channel with its shadow promoted, used wherever a new period or run begins.
      ch_ap = ch_q[i];
      if (pend_q[i]) begin
        ch_ap.div_act  = ch_q[i].div_sh;
        ch_ap.high_act = ch_q[i].high_sh;
`ifdef FREQ_DIV_MULTI_PHASE_EN
        ch_ap.phase_act = ch_q[i].phase_sh;
`endif
      end
`ifdef FREQ_DIV_MULTI_PHASE_EN
      start_pos = ch_ap.phase_act % ch_ap.div_act;
`else
      start_pos = '0;
`endif
      if (clear) begin
        ch_d[i]       = ch_ap;
        ch_d[i].state = ST_START;
        ch_d[i].count = start_pos;
        div_d[i]      = 1'b0;
        pend_d[i]     = 1'b0;
      end else begin
        if (en[i]) begin
          case (ch_q[i].state)
            ST_START: begin
              ch_d[i]       = ch_ap;
              ch_d[i].state = ST_RUN;
              ch_d[i].count = start_pos;
              div_d[i]      = start_pos < ch_ap.high_act;
              pend_d[i]     = 1'b0;
            end
            default: begin
              if (ch_q[i].count == ch_q[i].div_act - WIDTH'(1)) begin
                ch_d[i]       = ch_ap;
                ch_d[i].count = '0;
                tc_d[i]       = 1'b1;
                div_d[i]      = ch_ap.high_act != '0;
                pend_d[i]     = 1'b0;
              end else begin
                ch_d[i].count = ch_q[i].count + WIDTH'(1);
                div_d[i]      = (ch_q[i].count + WIDTH'(1)) < ch_q[i].high_act;
              end
            end
          endcase
        end
        // Capture after the wrap so a same-cycle write waits for the following boundary.
        if (wr_ok && int'(cfg.cfg_ch) == i) begin
          ch_d[i].div_sh  = cfg.cfg_div;
          ch_d[i].high_sh = cfg.cfg_high;
`ifdef FREQ_DIV_MULTI_PHASE_EN
          ch_d[i].phase_sh = cfg.cfg_phase;
`endif
          pend_d[i] = 1'b1;
        end
      end
    end
  end

  // NOTE: every per-channel register, shadows included, is reset so the config is known from the first edge.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        ch_q[i].state    <= ST_START;
        ch_q[i].count    <= '0;
        ch_q[i].div_act  <= WIDTH'(RST_DIV);
        ch_q[i].high_act <= WIDTH'(RST_HIGH);
        ch_q[i].div_sh   <= WIDTH'(RST_DIV);
        ch_q[i].high_sh  <= WIDTH'(RST_HIGH);
`ifdef FREQ_DIV_MULTI_PHASE_EN
        ch_q[i].phase_act <= '0;
        ch_q[i].phase_sh  <= '0;
`endif
      end
      div_q  <= '0;
      tc_q   <= '0;
      pend_q <= '0;
      err_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of order.
      ch_q   <= ch_d;
      div_q  <= div_d;
      tc_q   <= tc_d;
      pend_q <= pend_d;
      err_q  <= err_d;
    end
  end

  assign div         = div_q;
  assign tc          = tc_q;
  assign pend        = pend_q;
  assign cfg.cfg_err = err_q;

endmodule
